// File: rtl/muldiv_ctrl.sv
// HI/LO owner for the MIPS core: iterative 32-step multiply and restoring divide.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU are no-ops.
module muldiv_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Valid,
  input  logic [5:0]  Op,
  input  logic [5:0]  Func,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HiLoRdata,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      state_q;
  logic [4:0]  step_q;
  // Multiply: {partial product, multiplier}. Divide: low half holds dividend/quotient.
  logic [63:0] acc_q;
  logic [31:0] opnd_q;
  logic        sa_q, sb_q;
  logic [31:0] hi_q, lo_q;
`ifdef MULDIV_DIV_EN
  logic        is_div_q, div0_q;
  logic [32:0] rem_q;
  logic [31:0] araw_q;
`endif

  logic        rtype, dec_mfhi, dec_mflo, dec_mthi, dec_mtlo, dec_mul, dec_div;
  logic        dec_any, dec_signed;
  logic [31:0] amag, bmag;

  assign rtype    = Valid && (Op == 6'h00);
  assign dec_mfhi = rtype && (Func == 6'h10);
  assign dec_mthi = rtype && (Func == 6'h11);
  assign dec_mflo = rtype && (Func == 6'h12);
  assign dec_mtlo = rtype && (Func == 6'h13);
  assign dec_mul  = rtype && ((Func == 6'h18) || (Func == 6'h19));
`ifdef MULDIV_DIV_EN
  assign dec_div  = rtype && ((Func == 6'h1A) || (Func == 6'h1B));
`else
  assign dec_div  = 1'b0;
`endif
  assign dec_any    = dec_mfhi | dec_mflo | dec_mthi | dec_mtlo | dec_mul | dec_div;
  assign dec_signed = ~Func[0];

  assign amag = (dec_signed && A[31]) ? -A : A;
  assign bmag = (dec_signed && B[31]) ? -B : B;

  assign Busy      = (state_q != S_IDLE);
  assign Stall     = Busy && dec_any;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign HiLoRdata = dec_mfhi ? hi_q : (dec_mflo ? lo_q : '0);

  logic [32:0] mul_sum;
  logic [63:0] mul_next, prod_fix;
  logic [31:0] fix_hi, fix_lo;
`ifdef MULDIV_DIV_EN
  logic [32:0] div_sh, rem_next;
  logic [33:0] div_diff;
  logic [31:0] quo_next;
`endif

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    fix_hi   = prod_fix[63:32];
    fix_lo   = prod_fix[31:0];
`ifdef MULDIV_DIV_EN
    div_sh   = {rem_q[31:0], acc_q[31]};
    div_diff = {1'b0, div_sh} - {2'b00, opnd_q};
    rem_next = div_diff[33] ? div_sh : div_diff[32:0];
    quo_next = {acc_q[30:0], ~div_diff[33]};
    if (is_div_q) begin
      // Divide by zero reports the raw dividend and skips the sign fix.
      fix_lo = div0_q ? '1 : ((sa_q ^ sb_q) ? -acc_q[31:0] : acc_q[31:0]);
      fix_hi = div0_q ? araw_q : (sa_q ? -rem_q[31:0] : rem_q[31:0]);
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      rem_q    <= '0;
      araw_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dec_mthi) hi_q <= A;
          if (dec_mtlo) lo_q <= A;
          if (dec_mul || dec_div) begin
            state_q <= S_CALC;
            step_q  <= '0;
            sa_q    <= dec_signed && A[31];
            sb_q    <= dec_signed && B[31];
`ifdef MULDIV_DIV_EN
            is_div_q <= dec_div;
            div0_q   <= (B == 32'd0);
            rem_q    <= '0;
            araw_q   <= A;
`endif
            if (dec_div) begin
              acc_q  <= {32'd0, amag};
              opnd_q <= bmag;
            end else begin
              acc_q  <= {32'd0, bmag};
              opnd_q <= amag;
            end
          end
        end
        S_CALC: begin
          step_q <= step_q + 5'd1;
`ifdef MULDIV_DIV_EN
          if (is_div_q) begin
            acc_q <= {32'd0, quo_next};
            rem_q <= rem_next;
          end else begin
            acc_q <= mul_next;
          end
`else
          acc_q <= mul_next;
`endif
          if (step_q == 5'd31) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          step_q  <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl; divide checks follow MULDIV_DIV_EN.
module tb_muldiv_ctrl;

  logic        CLK = 1'b0;
  logic        RST, Valid;
  logic [5:0]  Op, Func;
  logic [31:0] A, B;
  logic        Busy, Stall;
  logic [31:0] HiLoRdata, HI, LO;

  int errors = 0;
  int checks = 0;
  int n;

  muldiv_ctrl dut (
    .CLK(CLK), .RST(RST), .Valid(Valid), .Op(Op), .Func(Func), .A(A), .B(B),
    .Busy(Busy), .Stall(Stall), .HiLoRdata(HiLoRdata), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    Valid = 1'b1; Op = 6'h00; Func = f; A = a; B = b;
  endtask

  task automatic quiet();
    Valid = 1'b0; Op = 6'h00; Func = 6'h00; A = '0; B = '0;
  endtask

  // Counts cycles with Busy high; bounded so a hung FSM still reaches the summary.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (Busy === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    RST = 1'b1;
    quiet();
    Func = 6'h10; Valid = 1'b1;
    tick(); tick();
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_mfhi", HiLoRdata, 32'd0);
    quiet();
    RST = 1'b0;
    tick();

    // MULT -2 * 3
    issue(6'h18, 32'hFFFFFFFE, 32'd3);
    #1 chk("mult_issue_stall", {31'd0, Stall}, 32'd0);
    tick();
    quiet();
    chk("mult_busy_k1", {31'd0, Busy}, 32'd1);
    wait_idle(n);
    chk("mult_busy_cycles", n, 32'd33);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFA);

    // MULTU max * max
    issue(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    quiet();
    wait_idle(n);
    chk("multu_cycles", n, 32'd33);
    chk("multu_hi", HI, 32'hFFFFFFFE);
    chk("multu_lo", LO, 32'h00000001);

    // Stall window: unrelated ops pass, MFLO holds until the result lands
    issue(6'h18, 32'd100, 32'd200);
    tick();
    tick(); tick(); tick(); tick();
    issue(6'h20, 32'd1, 32'd2);
    #1 chk("add_nostall", {31'd0, Stall}, 32'd0);
    chk("add_busy", {31'd0, Busy}, 32'd1);
    Op = 6'h23; Func = 6'h18;
    #1 chk("nonr_nostall", {31'd0, Stall}, 32'd0);
    issue(6'h12, 32'd0, 32'd0);
    #1 chk("mflo_stall", {31'd0, Stall}, 32'd1);
    n = 0;
    while (Stall === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("mflo_stall_cycles", n, 32'd29);
    chk("mflo_busy_after", {31'd0, Busy}, 32'd0);
    chk("mflo_new_lo", HiLoRdata, 32'd20000);
    chk("mflo_hi", HI, 32'd0);
    tick();
    quiet();

    // MTHI / MTLO in idle
    issue(6'h11, 32'h12345678, 32'd0);
    #1 chk("mthi_before_edge", HI, 32'd0);
    tick();
    chk("mthi_hi", HI, 32'h12345678);
    chk("mthi_lo_kept", LO, 32'd20000);
    issue(6'h10, 32'd0, 32'd0);
    #1 chk("mfhi_read", HiLoRdata, 32'h12345678);
    issue(6'h13, 32'hCAFEF00D, 32'd0);
    tick();
    chk("mtlo_lo", LO, 32'hCAFEF00D);
    issue(6'h12, 32'd0, 32'd0);
    #1 chk("mflo_read", HiLoRdata, 32'hCAFEF00D);
    quiet();
    #1 chk("idle_rdata_zero", HiLoRdata, 32'd0);

    // Back-to-back: second request is held until Busy drops
    issue(6'h19, 32'd2, 32'd3);
    tick();
    issue(6'h19, 32'd4, 32'd5);
    #1 chk("b2b_stall", {31'd0, Stall}, 32'd1);
    wait_idle(n);
    chk("b2b_first_cycles", n, 32'd33);
    chk("b2b_first_lo", LO, 32'd6);
    chk("b2b_accept_nostall", {31'd0, Stall}, 32'd0);
    tick();
    quiet();
    chk("b2b_second_busy", {31'd0, Busy}, 32'd1);
    wait_idle(n);
    chk("b2b_second_lo", LO, 32'd20);

`ifdef MULDIV_DIV_EN
    issue(6'h1A, 32'hFFFFFFF9, 32'd2);
    tick(); quiet(); wait_idle(n);
    chk("div_cycles", n, 32'd33);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);
    issue(6'h1B, 32'd10, 32'd0);
    tick(); quiet(); wait_idle(n);
    chk("divu0_lo", LO, 32'hFFFFFFFF);
    chk("divu0_hi", HI, 32'd10);
    issue(6'h1A, 32'h80000000, 32'hFFFFFFFF);
    tick(); quiet(); wait_idle(n);
    chk("div_ovf_lo", LO, 32'h80000000);
    chk("div_ovf_hi", HI, 32'd0);
    issue(6'h1A, 32'hFFFFFFFB, 32'd0);
    tick(); quiet(); wait_idle(n);
    chk("div0_neg_lo", LO, 32'hFFFFFFFF);
    chk("div0_neg_hi", HI, 32'hFFFFFFFB);
    issue(6'h1B, 32'd100, 32'd7);
    tick(); quiet(); wait_idle(n);
    chk("divu_lo", LO, 32'd14);
    chk("divu_hi", HI, 32'd2);
`else
    issue(6'h1A, 32'hFFFFFFF9, 32'd2);
    #1 chk("div_noop_stall", {31'd0, Stall}, 32'd0);
    tick();
    quiet();
    chk("div_noop_busy", {31'd0, Busy}, 32'd0);
    chk("div_noop_hi", HI, 32'd0);
    chk("div_noop_lo", LO, 32'd20);
`endif

    // Reset during CALC step 10 discards the operation
    issue(6'h18, 32'd1000, 32'd1000);
    tick();
    quiet();
    for (int i = 0; i < 10; i++) tick();
    chk("pre_rst_busy", {31'd0, Busy}, 32'd1);
    RST = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, Busy}, 32'd0);
    chk("midrst_stall", {31'd0, Stall}, 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    chk("midrst_rdata", HiLoRdata, 32'd0);
    tick();
    RST = 1'b0;
    tick();
    issue(6'h18, 32'd6, 32'd7);
    tick();
    quiet();
    wait_idle(n);
    chk("post_rst_cycles", n, 32'd33);
    chk("post_rst_lo", LO, 32'd42);
    chk("post_rst_hi", HI, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
